// File: rtl/instr_loader.sv
// Boot-time instruction memory loader: parses A5/N/payload/checksum frames into
// little-endian 32-bit words, writes them from address 0, and releases the CPU on a good checksum.
module instr_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 255
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic              load_req_i,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              cpu_rst_n_o,
  output logic              done_o,
  output logic              err_o,
  output logic [7:0]        words_o
);

  localparam logic [7:0] HEADER = 8'hA5;
  localparam logic [8:0] MAX_N  = 9'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_HUNT,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        n_q, n_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       wbuf_q, wbuf_d;

  logic              accept;
  logic [7:0]        words_inc;

  assign accept    = rx_valid_i & rdy_q;
  assign words_inc = words_q + 8'd1;

  // Every output comes straight from a flop, so reset forces it low at once and
  // the write strobe can never glitch.
  assign rx_ready_o  = rdy_q;
  assign im_we_o     = we_q;
  assign im_addr_o   = im_addr_q;
  assign im_wdata_o  = im_wdata_q;
  assign cpu_rst_n_o = cpu_rst_n_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign words_o     = words_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HUNT;
      rdy_q       <= 1'b0;
      we_q        <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
      addr_q      <= '0;
      chk_q       <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      wbuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      we_q        <= we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
      words_q     <= words_d;
      addr_q      <= addr_d;
      chk_q       <= chk_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      wbuf_q      <= wbuf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    err_d      = err_q;
    words_d    = words_q;
    addr_d     = addr_q;
    chk_d      = chk_q;
    n_d        = n_q;
    idx_d      = idx_q;
    wbuf_d     = wbuf_q;

    case (state_q)
      S_HUNT: begin
        if (accept && rx_data_i == HEADER) begin
          err_d   = 1'b0;
          words_d = '0;
          addr_d  = '0;
          chk_d   = '0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (accept) begin
          n_d   = rx_data_i;
          chk_d = rx_data_i;
          idx_d = '0;
          if ({1'b0, rx_data_i} > MAX_N) begin
            state_d = S_ERR;
          end else if (rx_data_i == 8'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d = chk_q ^ rx_data_i;
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0: wbuf_d[7:0]   = rx_data_i;
            2'd1: wbuf_d[15:8]  = rx_data_i;
            2'd2: wbuf_d[23:16] = rx_data_i;
            default: begin
              // Fourth byte completes the word; the write strobe follows one cycle later.
              we_d       = 1'b1;
              im_wdata_d = {rx_data_i, wbuf_q};
              im_addr_d  = addr_q;
              addr_d     = addr_q + ADDR_W'(4);
              words_d    = words_inc;
              if (words_inc == n_q) begin
                state_d = S_CHECK;
              end
            end
          endcase
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (rx_data_i == chk_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE: begin
        if (load_req_i) begin
          state_d = S_HUNT;
        end
      end
      S_ERR: begin
        state_d = S_HUNT;
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase

    rdy_d       = (state_d == S_HUNT) || (state_d == S_COUNT) ||
                  (state_d == S_DATA) || (state_d == S_CHECK);
    done_d      = (state_d == S_DONE);
    cpu_rst_n_d = (state_d == S_DONE);
    if (state_d == S_ERR) begin
      err_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table-driven frames plus hand-written
// sequences for stalls, error recovery, mid-frame reset and reload.
module tb_instr_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 16;

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rxData = 8'h00;
  logic              rxValid = 1'b0;
  logic              loadReq = 1'b0;
  logic              rx_ready_o;
  logic              im_we_o;
  logic [ADDR_W-1:0] im_addr_o;
  logic [31:0]       im_wdata_o;
  logic              cpu_rst_n_o;
  logic              done_o;
  logic              err_o;
  logic [7:0]        words_o;

  always #5 clk_i = ~clk_i;

  instr_loader #(
    .ADDR_W   (ADDR_W),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .rx_data_i  (rxData),
    .rx_valid_i (rxValid),
    .rx_ready_o (rx_ready_o),
    .load_req_i (loadReq),
    .im_we_o    (im_we_o),
    .im_addr_o  (im_addr_o),
    .im_wdata_o (im_wdata_o),
    .cpu_rst_n_o(cpu_rst_n_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .words_o    (words_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stalls = 0;
  int doublePulse = 0;
  logic prevWe = 1'b0;

  logic [ADDR_W-1:0] wrAddrs[$];
  logic [31:0]       wrDatas[$];
  int                wrCycs[$];
  int                byteCycs[$];
  logic [7:0]        pool[$];

  typedef struct {
    int         start;
    int         len;
    int         hdrIdx;
    int         expWrites;
    logic [31:0] expLastData;
    logic       expDone;
    logic       expErr;
    logic [7:0] expWords;
  } vec_t;

  vec_t vecs[6];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Write monitor: logs every strobe and flags strobes lasting more than one cycle.
  always @(negedge clk_i) begin
    if (im_we_o) begin
      wrAddrs.push_back(im_addr_o);
      wrDatas.push_back(im_wdata_o);
      wrCycs.push_back(cyc);
    end
    if (im_we_o && prevWe) doublePulse <= doublePulse + 1;
    prevWe <= im_we_o;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Holds the byte until the loader takes it; waits count as stalls.
  task automatic sendByte(input logic [7:0] b);
    int  waitCyc = 0;
    bit  taken = 0;
    rxData  = b;
    rxValid = 1'b1;
    while (!taken) begin
      @(negedge clk_i);
      if (rx_ready_o) begin
        @(posedge clk_i);
        #1;
        byteCycs.push_back(cyc);
        taken = 1;
      end else begin
        @(posedge clk_i);
        #1;
        waitCyc++;
        stalls++;
        if (waitCyc > 20) begin
          checks++;
          failures++;
          $display("[TB] FAIL handshake timeout: byte 0x%0h not accepted, required accept within 20 cycles", b);
          taken = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int start, input int len);
    for (int i = start; i < start + len; i++) sendByte(pool[i]);
    rxValid = 1'b0;
  endtask

  task automatic clearLogs();
    wrAddrs.delete();
    wrDatas.delete();
    wrCycs.delete();
    byteCycs.delete();
    stalls = 0;
  endtask

  task automatic doReset();
    rxValid = 1'b0;
    loadReq = 1'b0;
    rst_n   = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clearLogs();
  endtask

  initial begin
    int st;

    st = pool.size();
    pool = {pool, 8'hA5, 8'h01, 8'h20, 8'h00, 8'h08, 8'h20, 8'h09};
    vecs[0] = '{st, pool.size() - st, 0, 1, 32'h20080020, 1'b1, 1'b0, 8'd1};

    st = pool.size();
    pool = {pool, 8'h00, 8'h13, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h01, 8'h02, 8'h03, 8'h04, 8'h8F};
    vecs[1] = '{st, pool.size() - st, 2, 3, 32'h04030201, 1'b1, 1'b0, 8'd3};

    st = pool.size();
    pool = {pool, 8'h00, 8'h13, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h01, 8'h02, 8'h03, 8'h04, 8'h8E};
    vecs[2] = '{st, pool.size() - st, 2, 3, 32'h04030201, 1'b0, 1'b1, 8'd3};

    st = pool.size();
    pool = {pool, 8'hA5, 8'h00, 8'h00};
    vecs[3] = '{st, pool.size() - st, 0, 0, 32'h0, 1'b1, 1'b0, 8'd0};

    st = pool.size();
    pool = {pool, 8'hA5, 8'h11};
    vecs[4] = '{st, pool.size() - st, 0, 0, 32'h0, 1'b0, 1'b1, 8'd0};

    st = pool.size();
    pool = {pool, 8'hA5, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12, 8'h28};
    vecs[5] = '{st, pool.size() - st, 0, 2, 32'h12345678, 1'b1, 1'b0, 8'd2};

    // Reset state while rst_n is held low
    idle(2);
    checkOutput("reset rx_ready_o", rx_ready_o, 0);
    checkOutput("reset im_we_o", im_we_o, 0);
    checkOutput("reset im_addr_o", im_addr_o, 0);
    checkOutput("reset im_wdata_o", im_wdata_o, 0);
    checkOutput("reset cpu_rst_n_o", cpu_rst_n_o, 0);
    checkOutput("reset done_o", done_o, 0);
    checkOutput("reset err_o", err_o, 0);
    checkOutput("reset words_o", words_o, 0);

    for (int v = 0; v < 6; v++) begin
      doReset();
      applyStimulus(vecs[v].start, vecs[v].len);
      idle(3);
      checkOutput($sformatf("v%0d write count", v), wrAddrs.size(), vecs[v].expWrites);
      for (int j = 0; j < vecs[v].expWrites && j < wrAddrs.size(); j++) begin
        checkOutput($sformatf("v%0d addr[%0d]", v, j), wrAddrs[j], 4 * j);
        checkOutput($sformatf("v%0d latency[%0d]", v, j), wrCycs[j],
                    byteCycs[vecs[v].hdrIdx + 5 + 4 * j]);
      end
      if (vecs[v].expWrites > 0 && wrDatas.size() > 0)
        checkOutput($sformatf("v%0d last wdata", v), wrDatas[wrDatas.size() - 1], vecs[v].expLastData);
      checkOutput($sformatf("v%0d done_o", v), done_o, vecs[v].expDone);
      checkOutput($sformatf("v%0d err_o", v), err_o, vecs[v].expErr);
      checkOutput($sformatf("v%0d cpu_rst_n_o", v), cpu_rst_n_o, vecs[v].expDone);
      checkOutput($sformatf("v%0d words_o", v), words_o, vecs[v].expWords);
      checkOutput($sformatf("v%0d ready stalls", v), stalls, 0);
    end

    // Bad checksum, then a good frame clears err_o at its header
    doReset();
    applyStimulus(vecs[2].start, vecs[2].len);
    idle(2);
    checkOutput("recover err before", err_o, 1);
    sendByte(8'hA5);
    checkOutput("recover err at header", err_o, 0);
    applyStimulus(vecs[1].start + 3, vecs[1].len - 3);
    idle(3);
    checkOutput("recover done_o", done_o, 1);
    checkOutput("recover cpu_rst_n_o", cpu_rst_n_o, 1);
    checkOutput("recover write count", wrAddrs.size(), 6);

    // Valid drops for 5 cycles between payload bytes 2 and 3
    doReset();
    sendByte(8'hA5);
    sendByte(8'h02);
    sendByte(8'hEF);
    sendByte(8'hBE);
    rxValid = 1'b0;
    rxData  = 8'hFF;
    idle(5);
    applyStimulus(vecs[5].start + 4, vecs[5].len - 4);
    idle(3);
    checkOutput("stall write count", wrDatas.size(), 2);
    if (wrDatas.size() >= 2) begin
      checkOutput("stall wdata[0]", wrDatas[0], 32'hDEADBEEF);
      checkOutput("stall wdata[1]", wrDatas[1], 32'h12345678);
    end
    checkOutput("stall done_o", done_o, 1);

    // Reset pulse after 6 of 8 payload bytes, then a full reload
    doReset();
    applyStimulus(vecs[5].start, 8);
    checkOutput("midreset words before", words_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset rx_ready_o", rx_ready_o, 0);
    checkOutput("midreset im_we_o", im_we_o, 0);
    checkOutput("midreset im_addr_o", im_addr_o, 0);
    checkOutput("midreset im_wdata_o", im_wdata_o, 0);
    checkOutput("midreset cpu_rst_n_o", cpu_rst_n_o, 0);
    checkOutput("midreset done_o", done_o, 0);
    checkOutput("midreset err_o", err_o, 0);
    checkOutput("midreset words_o", words_o, 0);
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    idle(1);
    clearLogs();
    applyStimulus(vecs[1].start, vecs[1].len);
    idle(3);
    checkOutput("reload write count", wrAddrs.size(), 3);
    if (wrAddrs.size() > 0) begin
      checkOutput("reload addr[0]", wrAddrs[0], 0);
      checkOutput("reload wdata[0]", wrDatas[0], 32'h44332211);
    end
    checkOutput("reload done_o", done_o, 1);

    // Reload request from DONE
    loadReq = 1'b1;
    @(posedge clk_i);
    #1;
    loadReq = 1'b0;
    checkOutput("loadreq cpu_rst_n_o", cpu_rst_n_o, 0);
    checkOutput("loadreq rx_ready_o", rx_ready_o, 1);
    checkOutput("loadreq done_o", done_o, 0);

    idle(1);
    checkOutput("single-cycle strobes", doublePulse, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time writer for the CPU instruction memory: receives a framed byte stream, assembles little-endian 32-bit words, and writes them to consecutive word addresses from 0.
- Holds the CPU in reset while loading and releases it only after the frame checksum verifies.
- Sits between a host byte source and Simple_Single_CPU, and replaces the bench-side memory preload as the hardware path for filling the instruction memory.

Parameters:
- ADDR_W, 10: width of the byte address presented to instruction memory.
- MAX_WORDS, 255: largest accepted word count; it must be no more than 2^(ADDR_W-2) and no more than 255.

Ports:
- clk_i, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- rx_data_i, input, 8: incoming stream byte.
- rx_valid_i, input, 1: rx_data_i is valid.
- rx_ready_o, output, 1: loader accepts a byte; a transfer happens when rx_valid_i and rx_ready_o are both high on a rising edge.
- load_req_i, input, 1: single-cycle request to reload; honoured only in DONE.
- im_we_o, output, 1: instruction memory write strobe.
- im_addr_o, output, ADDR_W: byte address, always word aligned (bits [1:0] = 0).
- im_wdata_o, output, 32: word to write.
- cpu_rst_n_o, output, 1: active-low reset to the CPU.
- done_o, output, 1: load completed and checksum good.
- err_o, output, 1: sticky frame error.
- words_o, output, 8: number of words written in the current frame.

Behaviour:
- Reset values: rx_ready_o=0, im_we_o=0, im_addr_o=0, im_wdata_o=0, cpu_rst_n_o=0, done_o=0, err_o=0, words_o=0. The state machine enters HUNT.
- Frame format: header 0xA5, count N, then 4N payload bytes, then checksum byte. The checksum is the XOR of the N byte and all payload bytes.
- Byte order: the first payload byte of each word goes to bits [7:0] and the fourth to bits [31:24].
- HUNT:
  - rx_ready_o=1.
  - A non-0xA5 byte is discarded.
  - Accepting 0xA5 clears err_o, words_o, the address counter and the checksum accumulator, then moves to COUNT.
- COUNT:
  - rx_ready_o=1.
  - The accepted byte is stored as N and seeds the checksum.
  - N > MAX_WORDS leads to ERR.
  - N = 0 leads to CHECK.
  - Otherwise the state moves to DATA with the byte index at 0.
- DATA:
  - rx_ready_o=1.
  - Each accepted byte goes into the byte lane given by the index (0..3) and is XORed into the checksum.
  - On the 4th byte, im_we_o goes high for exactly one cycle on the next cycle, with im_addr_o/im_wdata_o valid in that same cycle.
  - After the write, the address advances by 4 and words_o increments.
  - When words_o reaches N, the state moves to CHECK.
  - Write latency is one cycle after the 4th byte handshake. rx_ready_o stays high, so back-to-back bytes are sustained with no bubbles.
- CHECK:
  - rx_ready_o=1.
  - If the accepted byte equals the accumulator, the state moves to DONE; otherwise it moves to ERR.
- DONE:
  - rx_ready_o=0, done_o=1, and cpu_rst_n_o=1 from the cycle after entry.
  - load_req_i=1 clears done_o, drives cpu_rst_n_o=0 in the next cycle, and returns to HUNT.
- ERR:
  - err_o=1 and cpu_rst_n_o stays 0. Words already written are not rolled back.
  - The state returns to HUNT on the next cycle with err_o still set; err_o clears only when the next header is accepted.
- im_we_o is low in every state except the single write cycle. The address wraps modulo 2^ADDR_W, which cannot be reached when MAX_WORDS is legal.
- If rx_valid_i drops mid-word, the loader holds its partial word and byte index indefinitely.
- rx_data_i is ignored whenever rx_valid_i=0.
- Asserting rst_n low at any point, including mid-frame, immediately forces all outputs to their reset values. No write strobe may glitch high.

Test Plan:
- Stream 0xA5,0x01,0x20,0x00,0x08,0x20,0x09 → one write: im_addr_o=0, im_wdata_o=0x20080020. Then done_o=1, cpu_rst_n_o=1, words_o=1.
- Stream 0x00,0x13,0xA5, N=3, 12 payload bytes, correct checksum, sent back-to-back → the first two bytes are discarded. Three writes follow at addresses 0,4,8, each exactly one cycle after its 4th byte. rx_ready_o stays continuously high until DONE.
- Same frame with the checksum byte XOR 0x01 → err_o=1, cpu_rst_n_o stays 0, done_o=0. A following correct frame clears err_o at its header and ends with done_o=1.
- Header followed by N=0x00, then checksum 0x00 → no write, done_o=1. The same frame with N=MAX_WORDS+1 → ERR with no write.
- rx_valid_i toggled off for 5 cycles between payload bytes 2 and 3 → im_wdata_o is identical to the no-stall run and no extra im_we_o pulse appears.
- rst_n pulsed low after 6 of 8 payload bytes → all outputs return to 0 at once. A fresh full frame afterwards loads correctly starting at address 0. In DONE, load_req_i pulse → cpu_rst_n_o=0 on the next cycle and rx_ready_o=1.
